keypad_matrix_scanner: RTL
==========================

Name: keypad_matrix_scanner

Overview:
- Parametrised row-scan keypad controller for an R×C switch matrix (default 4×3).
- Drives one row at a time and samples synchronised column inputs at a programmable dwell rate.
- Debounces press and release, and delivers one encoded key event per press over a valid/ready handshake.
- Sits between the keypad pins and the CPU peripheral/IO bus; replaces the fixed-size, undebounced scanner.

Parameters:
- ROWS, 4, number of driven matrix rows (≥2).
- COLS, 3, number of sensed matrix columns (≥2).
- SCAN_DIV, 1000, clk cycles per row dwell; a sample tick fires at the last cycle of each dwell (≥2).
- DEBOUNCE, 4, consecutive agreeing tick samples required to accept a press or a release (≥1).
- REPEAT_DELAY, 500, ticks held before the first auto-repeat (used only with KEYPAD_REPEAT_EN).
- REPEAT_RATE, 100, ticks between subsequent repeats (used only with KEYPAD_REPEAT_EN).

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- cols  in  COLS  raw column inputs, active high, asynchronous to clk.
- rows  out  ROWS  one-hot row drive, active high.
- key_valid  out  1  key event pending.
- key_code  out  CODE_W  encoded key, CODE_W = $clog2(ROWS*COLS).
- key_ready  in  1  consumer accepts the event.
- press  out  1  a debounced key is currently held.
- overrun  out  1  sticky; an event was lost; cleared by rst_n only.

Behaviour:
- Reset values: rows=1 (row 0 driven), key_valid=0, key_code=0, press=0, overrun=0, FSM=SCAN, all counters 0.
- cols passes through a 2-flop synchroniser. Samples are taken only on tick.
- tick: the divider counts 0..SCAN_DIV-1 and asserts at SCAN_DIV-1. The divider restarts on every row change.
- Column priority: the lowest-index set column wins.
- Key code: code = row*COLS + col. Example: row 2, col 1, COLS=3 → 7.
- States:
  - SCAN: on tick, if sampled cols==0, rows rotates left (row ROWS-1 wraps to row 0). Otherwise latch the winning col, set cnt=1 and go to DEBOUNCE; the row does not advance.
  - DEBOUNCE: on each tick, if the winning col is unchanged, cnt++. If it differs or no column is set, go to SCAN and advance the row. When cnt reaches DEBOUNCE, go to HELD, set press=1 and emit the event. With DEBOUNCE=1, the SCAN detect tick goes directly to HELD.
  - HELD: the row stays fixed. On a tick with cols==0, set cnt=1 and go to RELEASE. On a tick with any column set, hold.
  - RELEASE: on each tick with cols==0, cnt++. On a tick with any column set, return to HELD and emit nothing. When cnt reaches DEBOUNCE, set press=0, advance the row and go to SCAN.
- Latency: key_valid rises the clk after the DEBOUNCE-th agreeing tick.
- Emit:
  - If key_valid==0, load key_code and set key_valid=1.
  - If key_valid==1 and not accepted that cycle, drop the new event and set overrun=1.
  - If key_valid&&key_ready happen in the same cycle as an emit, load the new event and keep key_valid=1 (no overrun).
- Handshake: key_valid and key_code are held stable until key_valid&&key_ready. key_valid clears on the next clk unless reloaded.
- Multi-key: additional columns on the held row are ignored. Other rows are not scanned until release.
- Reset mid-operation: asynchronous return to the reset values above. A pending event is discarded.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined: in HELD, a repeat counter counts ticks. At REPEAT_DELAY an identical event is emitted, then one every REPEAT_RATE ticks while held. The counter is cleared on entry to HELD and on entry to RELEASE. Repeats follow the same overrun rule.
- Undefined: exactly one event per debounced press. The repeat logic and parameters are unused.

Decomposition:
- Package keypad_pkg holds:
  - the scan_state_t enum {SCAN, DEBOUNCE, HELD, RELEASE};
  - a function code_width(rows, cols) returning $clog2(rows*cols);
  - a function encode_key(row, col, cols).
- Sub-module keypad_tick_gen: SCAN_DIV divider with a restart input, giving a one-cycle tick output.

Test Plan (SCAN_DIV=4, DEBOUNCE=3, ROWS=4, COLS=3 unless stated):
- Idle, cols=0, 40 cycles → rows sequence 1,2,4,8,1 changing every 4 cycles; key_valid stays 0.
- Hold cols=3'b010 while rows=4'b0100 for ≥3 ticks, key_ready=1 → one key_valid pulse with key_code=7; press=1; rows frozen at 4'b0100.
- Bounce: col high 2 ticks, low 1 tick → no event; rows advance to 4'b1000.
- key_ready=0, press key 0 (row 0, col 0), release, then press key 5 (row 1, col 2) → key_code stays 0; overrun=1; after key_ready=1, key_valid drops and no code 5 appears.
- Release glitch: while held, cols=0 for 2 ticks then high → stays HELD, no new event; press=1.
- rst_n low during DEBOUNCE → rows=1, key_valid=0, press=0 immediately. With KEYPAD_REPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2, hold key 4 for 12 ticks → events at the debounce tick, then +5, +7, +9, +11 ticks later, all with code 4.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad matrix scanner.
//   scan_state_t : scanner FSM states
//   code_width   : key-code width for a rows x cols matrix
//   encode_key   : linear key code, row-major
package keypad_pkg;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StHeld,
    StRelease
  } scan_state_t;

  function automatic int unsigned code_width(int unsigned rows, int unsigned cols);
    return $clog2(rows * cols);
  endfunction

  function automatic int unsigned encode_key(int unsigned row, int unsigned col,
                                             int unsigned cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Row-dwell divider: counts 0..SCAN_DIV-1 and pulses tick_o for one cycle on the last count.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   restart_i : restart the dwell from count 0 on the next clock
//   tick_o    : one-cycle sample strobe
module keypad_tick_gen #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);

  logic [DivW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == DivW'(SCAN_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + DivW'(1);
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Debounced row-scan keypad controller for a ROWS x COLS switch matrix.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   cols      : raw column inputs, active high, asynchronous
//   rows      : one-hot row drive, active high
//   key_valid : key event pending (valid/ready source)
//   key_code  : row*COLS + col of the pending event
//   key_ready : consumer accepts the event
//   press     : a debounced key is currently held
//   overrun   : sticky, an event was dropped while one was pending
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS         = 4,
  parameter int unsigned COLS         = 3,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100,
  localparam int unsigned CODE_W      = code_width(ROWS, COLS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [COLS-1:0]   cols,
  output logic [ROWS-1:0]   rows,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  input  logic              key_ready,
  output logic              press,
  output logic              overrun
);

  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned CntW = $clog2(DEBOUNCE + 1);

  logic [COLS-1:0]   cols_meta_q, cols_sync_q;
  scan_state_t       state_q, state_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [ColW-1:0]   col_q, col_d, win_col;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic              valid_q, valid_d, overrun_q, overrun_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              tick, row_adv, any_col, emit, ev_emit, accept;

  keypad_tick_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart_i(row_adv),
    .tick_o   (tick)
  );

  // Lowest-index set column wins.
  always_comb begin
    any_col = |cols_sync_q;
    win_col = '0;
    for (int i = int'(COLS) - 1; i >= 0; i--) begin
      if (cols_sync_q[i]) begin
        win_col = ColW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + CntW'(1);
    emit    = 1'b0;
    row_adv = 1'b0;
    if (tick) begin
      case (state_q)
        StScan: begin
          if (!any_col) begin
            row_adv = 1'b1;
          end else begin
            col_d = win_col;
            cnt_d = CntW'(1);
            if (DEBOUNCE == 1) begin
              state_d = StHeld;
              emit    = 1'b1;
            end else begin
              state_d = StDebounce;
            end
          end
        end
        StDebounce: begin
          if (any_col && (win_col == col_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CntW'(DEBOUNCE)) begin
              state_d = StHeld;
              emit    = 1'b1;
            end
          end else begin
            state_d = StScan;
            row_adv = 1'b1;
          end
        end
        StHeld: begin
          if (!any_col) begin
            cnt_d = CntW'(1);
            if (DEBOUNCE == 1) begin
              state_d = StScan;
              row_adv = 1'b1;
            end else begin
              state_d = StRelease;
            end
          end
        end
        StRelease: begin
          if (any_col) begin
            state_d = StHeld;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CntW'(DEBOUNCE)) begin
              state_d = StScan;
              row_adv = 1'b1;
            end
          end
        end
        default: state_d = StScan;
      endcase
    end
    if (row_adv) begin
      row_d = (row_q == RowW'(ROWS - 1)) ? '0 : row_q + RowW'(1);
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

  logic [RepW-1:0] rep_q, rep_d, rep_inc;
  logic            rep_emit;

  // Counts held ticks; after the first repeat it folds back to REPEAT_DELAY so
  // every later repeat lands REPEAT_RATE ticks apart.
  always_comb begin
    rep_d    = rep_q;
    rep_emit = 1'b0;
    rep_inc  = rep_q + RepW'(1);
    if ((state_q != StHeld) || (state_d != StHeld)) begin
      rep_d = '0;
    end else if (tick) begin
      if (rep_inc == RepW'(REPEAT_DELAY)) begin
        rep_emit = 1'b1;
        rep_d    = rep_inc;
      end else if (rep_inc == RepW'(REPEAT_DELAY + REPEAT_RATE)) begin
        rep_emit = 1'b1;
        rep_d    = RepW'(REPEAT_DELAY);
      end else begin
        rep_d = rep_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end

  assign ev_emit = emit | rep_emit;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
  assign ev_emit = emit;
`endif

  // Event slot: a new event replaces a pending one only when it is being accepted.
  always_comb begin
    accept    = valid_q && key_ready;
    valid_d   = valid_q;
    code_d    = code_q;
    overrun_d = overrun_q;
    if (accept) begin
      valid_d = 1'b0;
    end
    if (ev_emit) begin
      if (!valid_q || accept) begin
        valid_d = 1'b1;
        code_d  = CODE_W'(encode_key(32'(row_q), 32'(col_d), COLS));
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cols_meta_q <= '0;
      cols_sync_q <= '0;
      state_q     <= StScan;
      row_q       <= '0;
      col_q       <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      code_q      <= '0;
      overrun_q   <= 1'b0;
    end else begin
      cols_meta_q <= cols;
      cols_sync_q <= cols_meta_q;
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      code_q      <= code_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rows      = ROWS'(1) << row_q;
  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign press     = (state_q == StHeld) || (state_q == StRelease);
  assign overrun   = overrun_q;

endmodule
